// File: rtl/flex_down_timer.sv
// rtl/flex_down_timer.sv - loadable down-counting interval timer with done pulse and optional auto-reload
//
// Purpose:
//   Generates intervals of a requested length (bit periods, timeouts,
//   inter-packet gaps). A controller loads a length, waits for done, and may
//   let the timer free-run periodically with auto_reload.
//
// Optional feature macro: FLEX_DOWN_PRESCALE_EN
//   When defined, adds the prescale port and an internal prescale counter so
//   that a decrement occurs only on every (prescale+1)-th enabled RUN cycle.
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   clear        in   synchronous abort, highest priority after reset
//   load         in   start/restart; samples load_val and auto_reload
//   load_val     in   requested interval in enabled ticks
//   auto_reload  in   periodic mode select, sampled on load
//   count_enable in   tick qualifier
//   prescale     in   ticks per decrement minus 1 (FLEX_DOWN_PRESCALE_EN only)
//   count_out    out  current remaining count
//   busy         out  high while running
//   done         out  one-cycle registered pulse at expiry
//   zero_flag    out  high when count_out == 0

module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4
`ifdef FLEX_DOWN_PRESCALE_EN
    ,
    parameter int PRESCALE_BITS = 4
`endif
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     auto_reload,
    input  logic                     count_enable,
`ifdef FLEX_DOWN_PRESCALE_EN
    input  logic [PRESCALE_BITS-1:0] prescale,
`endif
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     busy,
    output logic                     done,
    output logic                     zero_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [NUM_CNT_BITS-1:0] count;
    logic [NUM_CNT_BITS-1:0] reload_val;
    logic                    reload_mode;
    logic                    tick;

`ifdef FLEX_DOWN_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] presc_cnt;

    // A decrement happens on the enabled cycle where the prescale counter has
    // reached the programmed divide value; prescale is compared live.
    assign tick = (state == RUN) && count_enable && (presc_cnt == prescale);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            presc_cnt <= '0;
        end else if (clear || load || (state != RUN) || tick) begin
            presc_cnt <= '0;
        end else if (count_enable) begin
            presc_cnt <= presc_cnt + PRESCALE_BITS'(1);
        end
    end
`else
    assign tick = (state == RUN) && count_enable;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            count       <= '0;
            reload_val  <= '0;
            reload_mode <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                // Abort: any expiry that would have happened this edge is lost.
                state       <= IDLE;
                count       <= '0;
                reload_mode <= 1'b0;
            end else if (load) begin
                if (load_val != '0) begin
                    state       <= RUN;
                    count       <= load_val;
                    reload_val  <= load_val;
                    reload_mode <= auto_reload;
                end else begin
                    // Zero-length interval expires immediately.
                    state <= IDLE;
                    count <= '0;
                    done  <= 1'b1;
                end
            end else if (tick) begin
                // In RUN the count is never 0, so the terminal check on 1
                // guarantees no underflow through all-ones.
                if (count == NUM_CNT_BITS'(1)) begin
                    done <= 1'b1;
                    if (reload_mode) begin
                        count <= reload_val;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                    end
                end else begin
                    count <= count - NUM_CNT_BITS'(1);
                end
            end
        end
    end

    assign count_out = count;
    assign busy      = (state == RUN);
    assign zero_flag = (count == '0);

endmodule
